// File: rtl/panel_scan_pkg.sv
// Shared panel register map and the panel_scan FSM state type.
// Used by the panel slave and by panel_scan so both sides agree on addresses.
package panel_scan_pkg;

  // Panel register addresses (octal, matching the panel documentation)
  localparam logic [5:0] PanelAddrSet   = 6'o00;  // key set mask
  localparam logic [5:0] PanelAddrClr   = 6'o01;  // key clear mask
  localparam logic [5:0] PanelLampFirst = 6'o10;  // first lamp register
  localparam logic [5:0] PanelLampLast  = 6'o35;  // last lamp register

  localparam int unsigned NumKeys = 20;

  typedef enum logic [2:0] {
    StIdle,
    StKeySet,
    StKeyClr,
    StRead,
    StShift,
    StLatch
  } scan_state_e;

  // Key mask as written to the set/clear registers: mask in the low bits.
  function automatic logic [31:0] key_word(input logic [NumKeys-1:0] mask);
    return {{(32 - NumKeys){1'b0}}, mask};
  endfunction

endpackage

// File: rtl/panel_scan_lamp_shifter.sv
// Serialises one lamp word onto the lamp chain, MSB first.
// Ports:
//   clk, reset   : clock, async active-low reset
//   load         : one-cycle pulse, captures data and starts shifting
//   data         : word to shift
//   busy         : high while the word is being shifted
//   sclk, sdata  : lamp chain clock/data; sdata changes while sclk is low
module panel_scan_lamp_shifter #(
  parameter int unsigned SHIFT_DIV = 4,
  parameter int unsigned WORD_BITS = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [WORD_BITS-1:0] data,
  output logic                 busy,
  output logic                 sclk,
  output logic                 sdata
);

  localparam int unsigned BitW = $clog2(WORD_BITS + 1);
  localparam int unsigned DivW = $clog2(SHIFT_DIV + 1);
  localparam logic [BitW-1:0] LastBit = BitW'(WORD_BITS - 1);
  localparam logic [DivW-1:0] LastDiv = DivW'(SHIFT_DIV - 1);

  logic [WORD_BITS-1:0] shreg_q, shreg_d;
  logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DivW-1:0]      div_cnt_q, div_cnt_d;
  logic                 sclk_q, sclk_d;
  logic                 sdata_q, sdata_d;
  logic                 busy_q, busy_d;

  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    sclk_d    = sclk_q;
    sdata_d   = sdata_q;
    busy_d    = busy_q;
    if (load) begin
      // First bit goes straight to sdata; shreg holds the remaining bits.
      shreg_d   = data << 1;
      sdata_d   = data[WORD_BITS-1];
      bit_cnt_d = '0;
      div_cnt_d = '0;
      sclk_d    = 1'b0;
      busy_d    = 1'b1;
    end else if (busy_q) begin
      if (div_cnt_q == LastDiv) begin
        div_cnt_d = '0;
        if (!sclk_q) begin
          sclk_d = 1'b1;
        end else begin
          sclk_d = 1'b0;
          if (bit_cnt_q == LastBit) begin
            busy_d = 1'b0;  // sdata keeps the last bit
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            sdata_d   = shreg_q[WORD_BITS-1];
            shreg_d   = shreg_q << 1;
          end
        end
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      sclk_q    <= 1'b0;
      sdata_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      sclk_q    <= sclk_d;
      sdata_q   <= sdata_d;
      busy_q    <= busy_d;
    end
  end

  assign busy  = busy_q;
  assign sclk  = sclk_q;
  assign sdata = sdata_q;

endmodule

// File: rtl/panel_scan.sv
// Panel scanner: Avalon-MM master that reports key edges to the panel
// (set/clear mask writes) and streams lamp registers out to a serial lamp
// chain, one frame = SCAN_FIRST..SCAN_LAST followed by a latch pulse.
// Ports:
//   clk, reset        : clock, async active-low reset
//   scan_en           : enables lamp scanning (frames pause at word boundaries)
//   keys              : synchronised key levels, bit n = set/clear register bit n
//   m_address/m_read/m_write/m_writedata/m_readdata/m_waitrequest : Avalon master
//   lamp_sclk/lamp_sdata/lamp_latch : lamp chain
//   frame_done        : one-cycle pulse at end of frame (with lamp_latch)
module panel_scan
  import panel_scan_pkg::*;
#(
  parameter logic [5:0]  SCAN_FIRST = PanelLampFirst,
  parameter logic [5:0]  SCAN_LAST  = PanelLampLast,
  parameter int unsigned SHIFT_DIV  = 4,
  parameter int unsigned WORD_BITS  = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         scan_en,
  input  logic [19:0]  keys,
  output logic [5:0]   m_address,
  output logic         m_read,
  output logic         m_write,
  output logic [31:0]  m_writedata,
  input  logic [31:0]  m_readdata,
  input  logic         m_waitrequest,
  output logic         lamp_sclk,
  output logic         lamp_sdata,
  output logic         lamp_latch,
  output logic         frame_done
);

  scan_state_e          state_q, state_d;
  logic [5:0]           addr_q, addr_d;
  logic                 read_q, read_d;
  logic                 write_q, write_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [NumKeys-1:0]   key_prev_q, key_prev_d;
  logic [5:0]           scan_addr_q, scan_addr_d;
  logic [NumKeys-1:0]   rise, fall;
  logic                 shift_load, shift_busy;
  logic                 unused_rdata;

  assign rise = keys & ~key_prev_q;
  assign fall = ~keys & key_prev_q;

  // Only the shifted bits of the read word matter.
  assign unused_rdata = ^m_readdata;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    read_d      = read_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    key_prev_d  = key_prev_q;
    scan_addr_d = scan_addr_q;
    shift_load  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|rise) begin
          state_d = StKeySet;
          write_d = 1'b1;
          addr_d  = PanelAddrSet;
          wdata_d = key_word(rise);
        end else if (|fall) begin
          state_d = StKeyClr;
          write_d = 1'b1;
          addr_d  = PanelAddrClr;
          wdata_d = key_word(fall);
        end else if (scan_en) begin
          state_d = StRead;
          read_d  = 1'b1;
          addr_d  = scan_addr_q;
        end
      end
      // Only the bits actually reported are folded into key_prev, so edges
      // arriving during the write are seen on the next pass through idle.
      StKeySet: begin
        if (!m_waitrequest) begin
          write_d    = 1'b0;
          key_prev_d = key_prev_q | wdata_q[NumKeys-1:0];
          state_d    = StIdle;
        end
      end
      StKeyClr: begin
        if (!m_waitrequest) begin
          write_d    = 1'b0;
          key_prev_d = key_prev_q & ~wdata_q[NumKeys-1:0];
          state_d    = StIdle;
        end
      end
      StRead: begin
        if (!m_waitrequest) begin
          read_d     = 1'b0;
          shift_load = 1'b1;
          state_d    = StShift;
        end
      end
      StShift: begin
        if (!shift_busy) begin
          if (scan_addr_q != SCAN_LAST) begin
            scan_addr_d = scan_addr_q + 6'd1;
            state_d     = StIdle;
          end else begin
            state_d = StLatch;
          end
        end
      end
      StLatch: begin
        scan_addr_d = SCAN_FIRST;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      key_prev_q  <= '0;
      scan_addr_q <= SCAN_FIRST;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      read_q      <= read_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      key_prev_q  <= key_prev_d;
      scan_addr_q <= scan_addr_d;
    end
  end

  panel_scan_lamp_shifter #(
    .SHIFT_DIV (SHIFT_DIV),
    .WORD_BITS (WORD_BITS)
  ) u_shifter (
    .clk   (clk),
    .reset (reset),
    .load  (shift_load),
    .data  (m_readdata[WORD_BITS-1:0]),
    .busy  (shift_busy),
    .sclk  (lamp_sclk),
    .sdata (lamp_sdata)
  );

  assign m_address   = addr_q;
  assign m_read      = read_q;
  assign m_write     = write_q;
  assign m_writedata = wdata_q;
  assign lamp_latch  = (state_q == StLatch);
  assign frame_done  = (state_q == StLatch);

endmodule

// File: doc/panel_scan.md
PANEL_SCAN -- requirements
Module: panel_scan

Interface
REQ-001 SHALL have parameter SCAN_FIRST, default 6'o10, first panel register address read per frame.
REQ-002 SHALL have parameter SCAN_LAST, default 6'o35, last panel register address read per frame (SCAN_LAST >= SCAN_FIRST).
REQ-003 SHALL have parameter SHIFT_DIV, default 4, lamp_sclk half-period in clk cycles (>= 1).
REQ-004 SHALL have parameter WORD_BITS, default 24, low bits of each read word shifted out (1..32).
REQ-005 SHALL have ports, in order: clk in 1 system clock; reset in 1 async active-low reset; scan_en in 1 enables lamp scanning; keys in 20 synchronised key levels, bit order equal to panel set/clear register bits 0..19; m_address out 6 Avalon master address; m_read out 1 read strobe; m_write out 1 write strobe; m_writedata out 32 write data; m_readdata in 32 read data; m_waitrequest in 1 slave stall; lamp_sclk out 1 lamp chain clock; lamp_sdata out 1 lamp chain data; lamp_latch out 1 lamp chain latch pulse; frame_done out 1 one-cycle end-of-frame pulse.
REQ-006 Clock is clk, reset is reset; single clock domain, reset asynchronous active-low.

Function
REQ-007 SHALL be an Avalon-MM master; the panel slave sits at the far end: key set mask at 6'o00, key clear mask at 6'o01.
REQ-008 SHALL hold m_address, m_read, m_write, m_writedata stable while m_waitrequest=1; a transfer completes in the first cycle its strobe is high and m_waitrequest=0.
REQ-009 SHALL never assert m_read and m_write together; strobes drop the cycle after completion.
REQ-010 SHALL capture m_readdata in the completion cycle of a read (zero-latency slave).
REQ-011 SHALL keep register key_prev[19:0]; rise = keys & ~key_prev, fall = ~keys & key_prev, sampled when the FSM is in IDLE.
REQ-012 FSM states: IDLE, KEYSET, KEYCLR, READ, SHIFT, LATCH.
REQ-013 IDLE: if rise!=0 -> KEYSET with m_writedata={12'b0,rise}, m_address=6'o00; else if fall!=0 -> KEYCLR with {12'b0,fall} at 6'o01; else if scan_en -> READ at current scan address; else stay.
REQ-014 KEYSET/KEYCLR completion: key_prev updated only for the bits in the issued mask; return to IDLE; key changes during a write are picked up on the next IDLE.
REQ-015 Key writes SHALL have priority over scanning, but only at word boundaries; an in-progress READ/SHIFT/LATCH is never interrupted.
REQ-016 READ completion -> SHIFT with shift register loaded from m_readdata[WORD_BITS-1:0].
REQ-017 SHIFT: per bit, MSB first, lamp_sdata set with lamp_sclk=0 for SHIFT_DIV cycles, then lamp_sclk=1 for SHIFT_DIV cycles; a word takes exactly 2*SHIFT_DIV*WORD_BITS cycles.
REQ-018 After the last bit: if scan address != SCAN_LAST, increment address, go IDLE; else -> LATCH.
REQ-019 LATCH: lamp_latch=1 and frame_done=1 for exactly one cycle; scan address wraps to SCAN_FIRST; -> IDLE.
REQ-020 scan_en deasserted mid-frame: current word completes, frame resumes at the next address when re-enabled; no latch is issued until SCAN_LAST is shifted.
REQ-021 lamp_sclk SHALL be 0 outside SHIFT; lamp_sdata holds its last value.

Reset
REQ-022 On reset low, immediately: state IDLE; m_read, m_write, lamp_sclk, lamp_sdata, lamp_latch, frame_done = 0; m_address = 0; m_writedata = 0; key_prev = 0; scan address = SCAN_FIRST; shift/bit/divider counters = 0.
REQ-023 Reset mid-transfer SHALL abandon the transfer; after release, any key held high produces a fresh set write.

Structure
REQ-024 Panel register addresses (6'o00 set, 6'o01 clear, lamp range 6'o10..6'o35) SHALL live in a shared panel address package used by panel slave and this block.
REQ-025 One sub-module, lamp_shifter (load, data, busy, sclk, sdata, parameterised SHIFT_DIV/WORD_BITS), is natural; FSM and Avalon logic stay in panel_scan.

Verification
REQ-026 keys 0->20'h00008 -> one write, m_address=6'o00, m_writedata=32'h8; keys ->0 -> one write 6'o01, data 32'h8; no other writes.
REQ-027 m_waitrequest held 1 for 5 cycles on a write -> strobe, address, data stable all 5 cycles, completion on cycle 6, single write only.
REQ-028 scan_en=1, slave returns 32'hA5A5A5 at 6'o10 -> 24 sclk rises carrying A5A5A5 MSB first, word takes 192 cycles with defaults.
REQ-029 Full frame with defaults -> reads at 6'o10..6'o35 in order (22 reads), then exactly one lamp_latch/frame_done pulse, next read at 6'o10.
REQ-030 Key rise during SHIFT of word 6'o12 -> set write issued after that word, before read of 6'o13; frame still completes.
REQ-031 reset asserted during READ with m_waitrequest=1 -> all outputs zero same cycle; after release with keys=20'h1 -> first transfer is write 6'o00 data 32'h1.
